// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: 8-entry instruction store, PC sequencer, and a
// registered instruction slot with pre-split fields and opcode class.
module instr_fetch_decode #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    len,
  input  logic          start,
  input  logic          stall,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [AW-1:0] pc,
  output logic [2:0]    op,
  output logic [1:0]    rs,
  output logic [1:0]    rt,
  output logic [1:0]    rd,
  output logic [7:0]    shamt,
  output logic [7:0]    addr,
  output logic          illegal,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       illegal;
  } dec_t;

  state_t                 state, state_nxt;
  logic [DEPTH-1:0][31:0] mem;
  logic [AW-1:0]          fpc;
  logic [3:0]             cnt_len, issued;
  logic [31:0]            fetch_word;
  dec_t                   dec;
  logic                   can_load, issue, last;

  function automatic dec_t decode(input logic [7:0] ob);
    dec_t d;
    d.op      = 3'd7;
    d.illegal = 1'b0;
    case (ob)
      8'h20:   d.op = 3'd0;
      8'h10:   d.op = 3'd1;
      8'h08:   d.op = 3'd2;
      8'h04:   d.op = 3'd3;
      8'h40:   d.op = 3'd4;
      8'h80:   d.op = 3'd5;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  assign can_load   = (state != RUN);
  assign issue      = (state == RUN) && !stall;
  assign last       = issue && (issued + 4'd1 == cnt_len);
  assign fetch_word = mem[fpc];
  assign dec        = decode(fetch_word[31:24]);

  // Store is flop-based so reset can clear every entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      mem          <= '0;
    else if (can_load && wr_en)   mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (len == 4'd0) ? DONE : RUN;
      RUN:        if (last)  state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fpc        <= '0;
      issued     <= '0;
      cnt_len    <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      pc         <= '0;
      op         <= '0;
      illegal    <= 1'b0;
    end else if (can_load) begin
      // Slot contents hold after the run; only the valid flag drops.
      inst_valid <= 1'b0;
      if (start) begin
        fpc     <= '0;
        issued  <= '0;
        cnt_len <= (len > 4'd8) ? 4'd8 : len;
      end
    end else if (issue) begin
      inst       <= fetch_word;
      pc         <= fpc;
      op         <= dec.op;
      illegal    <= dec.illegal;
      inst_valid <= 1'b1;
      fpc        <= fpc + 1'b1;
      issued     <= issued + 4'd1;
    end
  end

  assign rs    = inst[17:16];
  assign rt    = inst[9:8];
  assign rd    = inst[1:0];
  assign shamt = inst[15:8];
  assign addr  = inst[23:16];
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed + randomized bench for instr_fetch_decode against a program-level
// model: a run of length N issues entries 0..N-1, each stall repeats a slot.
module tb_instr_fetch_decode;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  len = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [2:0]  pc;
  logic [2:0]  op;
  logic [1:0]  rs, rt, rd;
  logic [7:0]  shamt, addr;
  logic        illegal, busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [8];

  instr_fetch_decode #(.DEPTH(8), .AW(3)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .stall(stall), .inst_valid(inst_valid),
    .inst(inst), .pc(pc), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .addr(addr), .illegal(illegal), .busy(busy), .done(done)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] ref_op(input logic [31:0] w);
    case (w[31:24])
      8'h20:   return 3'd0;
      8'h10:   return 3'd1;
      8'h08:   return 3'd2;
      8'h04:   return 3'd3;
      8'h40:   return 3'd4;
      8'h80:   return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0] tbl [6] = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h40, 8'h80};
    int k = $urandom_range(0, 7);
    logic [7:0] ob = (k < 6) ? tbl[k] : 8'($urandom);
    return {ob, 24'($urandom)};
  endfunction

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic check_slot(input int idx);
    logic [31:0] w = mdl[idx];
    chk("valid", {31'd0, inst_valid}, 1);
    chk("pc", {29'd0, pc}, idx);
    chk("inst", inst, w);
    chk("op", {29'd0, op}, ref_op(w));
    chk("illegal", {31'd0, illegal}, (ref_op(w) == 3'd7) ? 1 : 0);
    chk("rs", {30'd0, rs}, w[17:16]);
    chk("rt", {30'd0, rt}, w[9:8]);
    chk("rd", {30'd0, rd}, w[1:0]);
    chk("shamt", {24'd0, shamt}, w[15:8]);
    chk("addr", {24'd0, addr}, w[23:16]);
  endtask

  // mode: -2 random stalls, -1 none, k>=0 stall scnt cycles once k issued.
  task automatic run_prog(input int n, input int mode, input int scnt,
                          input int abort_at, output int vcnt);
    int eff = (n > 8) ? 8 : n;
    int issued = 0, st = 0, st_valid = 0, guard = 0;
    logic do_stall;
    vcnt = 0;
    len = 4'(n); start = 1'b1;
    step();
    start = 1'b0; wr_en = 1'b0;
    if (eff == 0) begin
      chk("len0_done", {31'd0, done}, 1);
      chk("len0_busy", {31'd0, busy}, 0);
      chk("len0_valid", {31'd0, inst_valid}, 0);
      step();
      chk("len0_valid2", {31'd0, inst_valid}, 0);
      return;
    end
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_valid", {31'd0, inst_valid}, 0);
    while (issued < eff) begin
      if (guard++ > 64) begin
        chk("run_timeout", 0, 1);
        break;
      end
      if (mode == -2) do_stall = ($urandom_range(0, 2) == 0) && st < 6;
      else            do_stall = (issued == mode) && st < scnt;
      stall = do_stall;
      // Writes, starts and len changes while running must all be ignored.
      wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = $urandom;
      start = 1'($urandom); len = 4'($urandom);
      step();
      if (do_stall) begin
        st++;
        if (issued > 0) st_valid++;
      end else issued++;
      if (inst_valid === 1'b1) vcnt++;
      if (issued == 0) chk("pre_valid", {31'd0, inst_valid}, 0);
      else             check_slot(issued - 1);
      chk("busy", {31'd0, busy}, (issued == eff) ? 0 : 1);
      chk("done", {31'd0, done}, (issued == eff) ? 1 : 0);
      if (issued == abort_at) break;
    end
    stall = 1'b0; wr_en = 1'b0; start = 1'b0;
    if (issued == abort_at) return;
    stall = 1'($urandom);
    step();
    stall = 1'b0;
    if (inst_valid === 1'b1) vcnt++;
    chk("done_valid", {31'd0, inst_valid}, 0);
    chk("done_hold", {31'd0, done}, 1);
    chk("done_pc", {29'd0, pc}, eff - 1);
    chk("done_inst", inst, mdl[eff - 1]);
    chk("valid_cycles", vcnt, eff + st_valid);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {inst_valid, illegal, busy, done, op, pc, rs, rt, rd, shamt, addr}, 0);
    chk({tag, "_inst"}, inst, 0);
  endtask

  initial begin
    int v;
    foreach (mdl[i]) mdl[i] = '0;

    step(); step();
    chk_all_zero("reset");
    RST = 1'b0;
    step();

    // Basic four-instruction program.
    wr(0, 32'h20000102); wr(1, 32'h10020003); wr(2, 32'h08010201); wr(3, 32'h80050100);
    run_prog(4, -1, 0, -1, v);
    chk("p1_vcnt", v, 4);

    // Eight ST words with a two-cycle stall after the third issue.
    for (int i = 0; i < 8; i++) wr(i, 32'h40030200);
    run_prog(8, 3, 2, -1, v);
    chk("p2_vcnt", v, 10);

    // Illegal opcode still issues and execution continues.
    wr(0, 32'h33000000);
    run_prog(2, -1, 0, -1, v);

    // Zero-length program.
    run_prog(0, -1, 0, -1, v);

    // Write and start in the same cycle; first fetch sees the new word.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h04112233; mdl[0] = 32'h04112233;
    run_prog(3, -1, 0, -1, v);
    // Re-start shows the store unchanged by writes attempted during the run.
    run_prog(12, -2, 0, -1, v);

    // Reset in the middle of an 8-word run.
    for (int i = 0; i < 8; i++) wr(i, rand_word());
    run_prog(8, -1, 0, 2, v);
    #2 RST = 1'b1;
    #1 chk_all_zero("midrst");
    foreach (mdl[i]) mdl[i] = '0;
    step();
    RST = 1'b0;
    chk_all_zero("midrst_idle");
    run_prog(8, -1, 0, -1, v);
    wr(5, 32'h10aa0101);
    run_prog(6, -1, 0, -1, v);

    // Randomized programs, lengths and stalls.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 8; i++) if (($urandom & 1) != 0) wr(i, rand_word());
      run_prog($urandom_range(0, 15), -2, 0, -1, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
